// File: rtl/pic_init_sequencer.sv
// Initialization and operation command-word sequencer for an 8259-style PIC.
// Writes commit on the trailing edge of the write strobe; reads are registered.
module pic_init_sequencer #(
  parameter logic [7:0] OCW3_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       csn,
  input  logic       wrn,
  input  logic       rdn,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  output logic [7:0] icw1,
  output logic [7:0] icw2,
  output logic [7:0] icw3,
  output logic [7:0] icw4,
  output logic [7:0] ocw1,
  output logic [7:0] ocw2,
  output logic [7:0] ocw3,
  output logic       ocw2_stb,
  output logic [2:0] state,
  output logic       init_done,
  output logic [7:0] dout,
  output logic       dout_en
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ICW2 = 3'd1,
    S_WAIT_ICW3 = 3'd2,
    S_WAIT_ICW4 = 3'd3,
    S_READY     = 3'd4
  } state_t;

  state_t     state_r, state_nx;
  logic       wr_act, wr_act_q, wr_block, commit, rd_act;
  logic [7:0] din_q;
  logic       a0_q;
  logic [7:0] icw1_nx, icw2_nx, icw3_nx, icw4_nx, ocw1_nx, ocw2_nx, ocw3_nx;
  logic       stb_nx;

  assign wr_act = ~csn & ~wrn;
  assign commit = wr_act_q & ~wr_act;
  assign rd_act = ~csn & ~rdn & ~wr_act;
  assign state  = state_r;

  // Write capture; wr_block keeps a write that straddled reset from ever committing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_act_q <= 1'b0;
      wr_block <= 1'b1;
      din_q    <= 8'h00;
      a0_q     <= 1'b0;
    end else begin
      wr_act_q <= wr_act & ~wr_block;
      if (!wr_act) begin
        wr_block <= 1'b0;
      end
      if (wr_act && !wr_block) begin
        din_q <= din;
        a0_q  <= a0;
      end
    end
  end

  always_comb begin
    state_nx = state_r;
    icw1_nx  = icw1;
    icw2_nx  = icw2;
    icw3_nx  = icw3;
    icw4_nx  = icw4;
    ocw1_nx  = ocw1;
    ocw2_nx  = ocw2;
    ocw3_nx  = ocw3;
    stb_nx   = 1'b0;
    if (commit) begin
      if (!a0_q && din_q[4]) begin
        icw1_nx  = din_q;
        icw2_nx  = 8'h00;
        icw3_nx  = 8'h00;
        icw4_nx  = 8'h00;
        ocw1_nx  = 8'h00;
        ocw2_nx  = 8'h00;
        ocw3_nx  = OCW3_RST;
        state_nx = S_WAIT_ICW2;
      end else begin
        case (state_r)
          S_WAIT_ICW2: begin
            if (a0_q) begin
              icw2_nx = din_q;
              if (!icw1[1])     state_nx = S_WAIT_ICW3;
              else if (icw1[0]) state_nx = S_WAIT_ICW4;
              else              state_nx = S_READY;
            end
          end
          S_WAIT_ICW3: begin
            if (a0_q) begin
              icw3_nx  = din_q;
              state_nx = icw1[0] ? S_WAIT_ICW4 : S_READY;
            end
          end
          S_WAIT_ICW4: begin
            if (a0_q) begin
              icw4_nx  = din_q;
              state_nx = S_READY;
            end
          end
          S_READY: begin
            if (a0_q) begin
              ocw1_nx = din_q;
            end else if (din_q[4:3] == 2'b00) begin
              ocw2_nx = din_q;
              stb_nx  = 1'b1;
            end else if (din_q[4:3] == 2'b01) begin
              // read-register select bits only move when RR is set
              ocw3_nx = {din_q[7:2], din_q[1] ? din_q[1:0] : ocw3[1:0]};
            end else begin
              ocw3_nx = ocw3;
            end
          end
          default: begin
            state_nx = state_r;
          end
        endcase
      end
    end else begin
      stb_nx = 1'b0;
    end
  end

  // Sequencer state and command-word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      init_done <= 1'b0;
      icw1      <= 8'h00;
      icw2      <= 8'h00;
      icw3      <= 8'h00;
      icw4      <= 8'h00;
      ocw1      <= 8'h00;
      ocw2      <= 8'h00;
      ocw3      <= OCW3_RST;
      ocw2_stb  <= 1'b0;
    end else begin
      state_r   <= state_nx;
      init_done <= (state_nx == S_READY);
      icw1      <= icw1_nx;
      icw2      <= icw2_nx;
      icw3      <= icw3_nx;
      icw4      <= icw4_nx;
      ocw1      <= ocw1_nx;
      ocw2      <= ocw2_nx;
      ocw3      <= ocw3_nx;
      ocw2_stb  <= stb_nx;
    end
  end

  // Registered read path; dout holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout    <= 8'h00;
      dout_en <= 1'b0;
    end else begin
      dout_en <= rd_act;
      if (rd_act) begin
        if (a0)                      dout <= ocw1;
        else if (ocw3[1:0] == 2'b11) dout <= isr;
        else                         dout <= irr;
      end
    end
  end

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Self-checking bench for pic_init_sequencer: directed scenarios plus random
// bus traffic compared against a command-word level reference model.
module tb_pic_init_sequencer;

  localparam logic [7:0] P_OCW3 = 8'h02;

  logic       clk = 1'b0;
  logic       rst, csn, wrn, rdn, a0;
  logic [7:0] din, irr, isr;
  logic [7:0] icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, dout;
  logic       ocw2_stb, init_done, dout_en;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;

  // reference model
  logic [2:0] m_st;
  logic [7:0] m_icw1, m_icw2, m_icw3, m_icw4, m_ocw1, m_ocw2, m_ocw3, m_dout;
  int         m_stb = 0;

  logic [59:0] dut_vec;
  assign dut_vec = {state, icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, init_done};

  pic_init_sequencer #(.OCW3_RST(P_OCW3)) dut (
    .clk(clk), .rst(rst), .csn(csn), .wrn(wrn), .rdn(rdn), .a0(a0), .din(din),
    .irr(irr), .isr(isr), .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .ocw1(ocw1), .ocw2(ocw2), .ocw3(ocw3), .ocw2_stb(ocw2_stb), .state(state),
    .init_done(init_done), .dout(dout), .dout_en(dout_en)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ocw2_stb === 1'b1) stb_cnt++;

  function automatic logic [59:0] model_vec();
    return {m_st, m_icw1, m_icw2, m_icw3, m_icw4, m_ocw1, m_ocw2, m_ocw3, (m_st == 3'd4)};
  endfunction

  task automatic model_reset();
    m_st = 3'd0; m_icw1 = 8'h00; m_icw2 = 8'h00; m_icw3 = 8'h00; m_icw4 = 8'h00;
    m_ocw1 = 8'h00; m_ocw2 = 8'h00; m_ocw3 = P_OCW3; m_dout = 8'h00;
  endtask

  task automatic model_write(input logic wa0, input logic [7:0] d);
    if (!wa0 && d[4]) begin
      m_icw1 = d; m_icw2 = 8'h00; m_icw3 = 8'h00; m_icw4 = 8'h00;
      m_ocw1 = 8'h00; m_ocw2 = 8'h00; m_ocw3 = P_OCW3; m_st = 3'd1;
    end else if (m_st == 3'd1 && wa0) begin
      m_icw2 = d;
      m_st = !m_icw1[1] ? 3'd2 : (m_icw1[0] ? 3'd3 : 3'd4);
    end else if (m_st == 3'd2 && wa0) begin
      m_icw3 = d;
      m_st = m_icw1[0] ? 3'd3 : 3'd4;
    end else if (m_st == 3'd3 && wa0) begin
      m_icw4 = d;
      m_st = 3'd4;
    end else if (m_st == 3'd4) begin
      if (wa0) m_ocw1 = d;
      else if (d[4:3] == 2'b00) begin m_ocw2 = d; m_stb++; end
      else if (d[1]) m_ocw3 = d;
      else m_ocw3 = {d[7:2], m_ocw3[1:0]};
    end
  endtask

  task automatic model_read(input logic ra0);
    if (ra0) m_dout = m_ocw1;
    else if (m_ocw3[1:0] == 2'b11) m_dout = isr;
    else m_dout = irr;
  endtask

  task automatic do_write(input logic wa0, input logic [7:0] d, input int hold);
    @(negedge clk);
    csn = 1'b0; wrn = 1'b0; a0 = wa0; din = d;
    repeat (hold) @(negedge clk);
    csn = 1'b1; wrn = 1'b1;
    @(negedge clk);
    #1;
    model_write(wa0, d);
  endtask

  task automatic do_read(input logic ra0, output logic [7:0] obs, output logic obs_en);
    @(negedge clk);
    csn = 1'b0; rdn = 1'b0; a0 = ra0;
    @(negedge clk);
    obs = dout; obs_en = dout_en;
    model_read(ra0);
    csn = 1'b1; rdn = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; csn = 1'b1; wrn = 1'b1; rdn = 1'b1; a0 = 1'b0; din = 8'h00;
    irr = 8'h00; isr = 8'h00;
    #2;
    model_reset();
    checks++;
    if (dut_vec !== model_vec() || dout !== 8'h00 || dout_en !== 1'b0 || ocw2_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h/%b/%b want %h/00/0/0", dut_vec, dout, dout_en, ocw2_stb, model_vec());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_write(1'b1, 8'hAA, 1);
    do_write(1'b0, 8'h08, 1);
    checks++;
    if (state !== 3'd0 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL idle_ignores_non_icw1: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_single_init();
    logic [2:0] exp_st [3] = '{3'd1, 3'd3, 3'd4};
    logic [7:0] bytes [3] = '{8'h13, 8'h20, 8'h01};
    logic       addr  [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_write(addr[i], bytes[i], 1);
      checks++;
      if (state !== exp_st[i] || init_done !== (exp_st[i] == 3'd4)) begin
        errors++;
        $display("FAIL single_init_step%0d: state=%0d done=%b want %0d", i, state, init_done, exp_st[i]);
      end
    end
    checks++;
    if (icw3 !== 8'h00 || icw2 !== 8'h20 || icw4 !== 8'h01 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL single_init_regs: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_cascade_init();
    logic [2:0] exp_st [3] = '{3'd1, 3'd2, 3'd4};
    logic [7:0] bytes [3] = '{8'h10, 8'h40, 8'h04};
    logic       addr  [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_write(addr[i], bytes[i], 1);
      checks++;
      if (state !== exp_st[i]) begin
        errors++;
        $display("FAIL cascade_step%0d: state=%0d want %0d", i, state, exp_st[i]);
      end
    end
    checks++;
    if (icw4 !== 8'h00 || icw3 !== 8'h04 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL cascade_regs: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_ready_ops();
    logic [7:0] obs;
    logic       en;
    int         s0;
    irr = 8'h5A; isr = 8'h08;
    do_write(1'b1, 8'hF0, 1);
    do_read(1'b1, obs, en);
    checks++;
    if (obs !== 8'hF0 || en !== 1'b1) begin
      errors++;
      $display("FAIL read_ocw1: dout=%h en=%b want f0 1", obs, en);
    end
    do_read(1'b0, obs, en);
    checks++;
    if (obs !== 8'h5A || en !== 1'b1) begin
      errors++;
      $display("FAIL read_irr: dout=%h en=%b want 5a 1", obs, en);
    end
    do_write(1'b0, 8'h0B, 1);
    do_read(1'b0, obs, en);
    checks++;
    if (obs !== 8'h08 || en !== 1'b1) begin
      errors++;
      $display("FAIL read_isr: dout=%h en=%b want 08 1", obs, en);
    end
    do_write(1'b0, 8'h08, 1);
    checks++;
    if (ocw3 !== 8'h0B) begin
      errors++;
      $display("FAIL ocw3_rr_retain: ocw3=%h want 0b", ocw3);
    end
    do_read(1'b0, obs, en);
    @(negedge clk);
    checks++;
    if (obs !== 8'h08 || dout_en !== 1'b0 || dout !== 8'h08) begin
      errors++;
      $display("FAIL read_isr_hold: dout=%h en=%b want 08 0", obs, dout_en);
    end
    s0 = stb_cnt;
    do_write(1'b0, 8'h20, 1);
    checks++;
    if (ocw2 !== 8'h20 || stb_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL ocw2_pulse: ocw2=%h pulses=%0d want 20 1", ocw2, stb_cnt - s0);
    end
  endtask

  task automatic test_ocw2_ignored();
    int s0;
    do_write(1'b0, 8'h13, 1);
    s0 = stb_cnt;
    do_write(1'b0, 8'h20, 1);
    checks++;
    if (state !== 3'd1 || ocw2 !== 8'h00 || stb_cnt !== s0) begin
      errors++;
      $display("FAIL ocw2_in_wait: state=%0d ocw2=%h pulses=%0d want 1 00 0", state, ocw2, stb_cnt - s0);
    end
    do_write(1'b1, 8'h20, 1);
    do_write(1'b1, 8'h01, 1);
  endtask

  task automatic test_reinit();
    do_write(1'b1, 8'hFF, 1);
    checks++;
    if (ocw1 !== 8'hFF) begin
      errors++;
      $display("FAIL ocw1_ff: ocw1=%h want ff", ocw1);
    end
    do_write(1'b0, 8'h17, 1);
    checks++;
    if (ocw1 !== 8'h00 || state !== 3'd1 || init_done !== 1'b0 || ocw3 !== P_OCW3) begin
      errors++;
      $display("FAIL reinit: ocw1=%h state=%0d done=%b ocw3=%h want 00 1 0 %h", ocw1, state, init_done, ocw3, P_OCW3);
    end
    do_write(1'b1, 8'h20, 1);
    do_write(1'b1, 8'h03, 1);
  endtask

  task automatic test_hold_and_abort();
    int s0;
    s0 = stb_cnt;
    @(negedge clk);
    csn = 1'b0; wrn = 1'b0; a0 = 1'b0; din = 8'h60;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ocw2 !== m_ocw2 || stb_cnt !== s0) begin
      errors++;
      $display("FAIL hold_no_early_commit: ocw2=%h pulses=%0d want %h 0", ocw2, stb_cnt - s0, m_ocw2);
    end
    csn = 1'b1; wrn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    model_write(1'b0, 8'h60);
    checks++;
    if (ocw2 !== 8'h60 || stb_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL hold_single_commit: ocw2=%h pulses=%0d want 60 1", ocw2, stb_cnt - s0);
    end
    @(negedge clk);
    csn = 1'b0; wrn = 1'b0; a0 = 1'b1; din = 8'h3C;
    @(negedge clk);
    csn = 1'b1;
    din = 8'hC3;
    @(negedge clk);
    #1;
    model_write(1'b1, 8'h3C);
    checks++;
    if (ocw1 !== 8'h3C) begin
      errors++;
      $display("FAIL abort_commit: ocw1=%h want 3c", ocw1);
    end
    wrn = 1'b1;
  endtask

  task automatic test_collision();
    @(negedge clk);
    csn = 1'b0; wrn = 1'b0; rdn = 1'b0; a0 = 1'b1; din = 8'h81;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (dout_en !== 1'b0 || dout !== m_dout) begin
        errors++;
        $display("FAIL collision_read_suppressed%0d: en=%b dout=%h want 0 %h", i, dout_en, dout, m_dout);
      end
    end
    csn = 1'b1; wrn = 1'b1; rdn = 1'b1;
    @(negedge clk);
    #1;
    model_write(1'b1, 8'h81);
    checks++;
    if (ocw1 !== 8'h81 || dout_en !== 1'b0 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL collision_write: got %h en=%b want %h", dut_vec, dout_en, model_vec());
    end
  endtask

  task automatic test_reset_mid_write();
    do_write(1'b0, 8'h13, 1);
    @(negedge clk);
    csn = 1'b0; wrn = 1'b0; a0 = 1'b1; din = 8'h55;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (state !== 3'd0 || icw2 !== 8'h00 || dut_vec !== model_vec() || dout !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %h dout=%h want %h 00", dut_vec, dout, model_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    csn = 1'b1; wrn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 3'd0 || icw2 !== 8'h00 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL reset_discards_write: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] obs, d;
    logic       en, wa0;
    for (int i = 0; i < 400; i++) begin
      irr = 8'($urandom());
      isr = 8'($urandom());
      if ($urandom_range(0, 3) == 0) begin
        wa0 = 1'($urandom());
        do_read(wa0, obs, en);
        checks++;
        if (obs !== m_dout || en !== 1'b1) begin
          errors++;
          $display("FAIL random_read%0d: dout=%h en=%b want %h 1", i, obs, en, m_dout);
        end
      end else begin
        wa0 = ($urandom_range(0, 9) < ((m_st != 3'd0 && m_st != 3'd4) ? 8 : 4));
        d = 8'($urandom());
        if (!wa0 && $urandom_range(0, 9) < 7) d[4] = 1'b0;
        do_write(wa0, d, $urandom_range(1, 3));
        checks++;
        if (dut_vec !== model_vec() || stb_cnt !== m_stb) begin
          errors++;
          $display("FAIL random_write%0d: got %h pulses=%0d want %h pulses=%0d", i, dut_vec, stb_cnt, model_vec(), m_stb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_init();
    test_cascade_init();
    test_ready_ops();
    test_ocw2_ignored();
    test_reinit();
    test_hold_and_abort();
    test_collision();
    test_reset_mid_write();
    m_stb = stb_cnt;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_init_sequencer.md
PIC_INIT_SEQUENCER -- requirements
Module: pic_init_sequencer

Interface
REQ-001 The parameter list SHALL be exactly: OCW3_RST, default 8'h00, the value loaded into ocw3 on reset and on every accepted ICW1.
REQ-002 The port list SHALL be, in order:
- clk, input, 1, the single clock; all state changes on its rising edge.
- rst, input, 1, reset, asynchronous and active-high.
- csn, input, 1, chip select, active-low.
- wrn, input, 1, write strobe, active-low.
- rdn, input, 1, read strobe, active-low.
- a0, input, 1, register address bit.
- din, input, 8, CPU write data, bit 0 = LSB.
- irr, input, 8, interrupt request register value, for readback.
- isr, input, 8, in-service register value, for readback.
- icw1, icw2, icw3, icw4, output, 8 each, latched initialization command words.
- ocw1, output, 8, interrupt mask (IMR).
- ocw2, output, 8, last OCW2 written.
- ocw3, output, 8, last OCW3 written.
- ocw2_stb, output, 1, one-cycle pulse when ocw2 is committed.
- state, output, 3, sequencer state: IDLE=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4.
- init_done, output, 1, high iff state==READY.
- dout, output, 8, registered read data.
- dout_en, output, 1, drive-enable for dout.

Function
REQ-003 The block SHALL compute wr_act = ~csn & ~wrn and register it as wr_act_q every cycle.
REQ-004 While wr_act=1, the block SHALL capture din into din_q and a0 into a0_q every cycle.
REQ-005 A write SHALL commit on the clock edge of the cycle where wr_act_q=1 and wr_act=0 (trailing edge), using din_q/a0_q; the updated register is visible the following cycle.
REQ-006 A commit with a0_q=0 and din_q[4]=1 SHALL be accepted as ICW1 in any state. It SHALL load icw1, clear icw2/icw3/icw4/ocw1/ocw2 to 0, load ocw3 with OCW3_RST, and go to WAIT_ICW2.
REQ-007 In WAIT_ICW2, a commit with a0_q=1 SHALL load icw2. The next state SHALL be WAIT_ICW3 if icw1[1]=0, else WAIT_ICW4 if icw1[0]=1, else READY.
REQ-008 In WAIT_ICW3, a commit with a0_q=1 SHALL load icw3. The next state SHALL be WAIT_ICW4 if icw1[0]=1, else READY.
REQ-009 In WAIT_ICW4, a commit with a0_q=1 SHALL load icw4 and go to READY.
REQ-010 In IDLE, WAIT_ICW2, WAIT_ICW3 and WAIT_ICW4, any non-ICW1 commit not covered by REQ-007..009 SHALL be ignored, with no register or state change.
REQ-011 In READY, a commit with a0_q=1 SHALL load ocw1.
REQ-012 In READY, a commit with a0_q=0, din_q[4:3]=2'b00 SHALL load ocw2 and pulse ocw2_stb high for exactly one cycle.
REQ-013 In READY, a commit with a0_q=0, din_q[4:3]=2'b01 SHALL load ocw3. Bits [1:0] SHALL update only when din_q[1]=1; otherwise the previous ocw3[1:0] SHALL be retained.
REQ-014 Reads: rd_act = ~csn & ~rdn & ~wr_act. Registered dout_en SHALL equal rd_act delayed one cycle.
REQ-015 Read data, registered one cycle after rd_act, SHALL be selected as follows:
- a0=1 → ocw1;
- a0=0 and ocw3[1:0]==2'b11 → isr;
- a0=0 otherwise → irr.
When rd_act=0, dout SHALL hold its previous value.
REQ-016 When read and write are active simultaneously, the write SHALL take priority and the read SHALL be suppressed (dout_en=0).
REQ-017 A write held active across multiple cycles SHALL commit exactly once, at its trailing edge.
REQ-018 A write aborted by csn rising before wrn rising SHALL still commit at the cycle wr_act falls, using the last captured data.

Reset
REQ-019 Asserting rst SHALL immediately force the following, independent of clk:
- state=IDLE, init_done=0;
- icw1..icw4, ocw1, ocw2 = 0, ocw3=OCW3_RST;
- ocw2_stb=0, dout=0, dout_en=0;
- wr_act_q=0, din_q=0, a0_q=0.
REQ-020 Reset asserted mid-write SHALL discard the pending write; no commit SHALL occur after rst deasserts, even if wrn is still low.
REQ-021 After reset deassertion, only an ICW1 SHALL leave IDLE.

Verification
REQ-022 Single-mode init: ICW1=8'h13, then ICW2=8'h20 (a0=1), then ICW4=8'h01 → state 0→1→3→4; icw3 stays 0; init_done=1 one cycle after the ICW4 trailing edge.
REQ-023 Cascade init without ICW4: ICW1=8'h10, ICW2=8'h40, ICW3=8'h04 → state 0→1→2→4; icw4=0.
REQ-024 In READY: write OCW1=8'hF0, then read with a0=1 → dout=8'hF0 with dout_en=1. Write OCW3=8'h0B, then read with a0=0 (isr=8'h08) → dout=8'h08. Write OCW3=8'h08 (RR=0), then read with a0=0 → still 8'h08.
REQ-025 OCW2=8'h20 in READY → ocw2=8'h20 and ocw2_stb high for one cycle. The same byte written in WAIT_ICW2 with a0=0 → ignored, no pulse.
REQ-026 Re-init: in READY with ocw1=8'hFF, write ICW1=8'h17 → ocw1=0, state=WAIT_ICW2, init_done=0.
REQ-027 Reset and collision: rst pulsed while wrn is low during ICW2 → state=IDLE and icw2=0 immediately, with no commit after release. Simultaneous rdn/wrn low → dout_en stays 0 and the write commits.
